// File: rtl/mem_responder_if.sv
// mem_responder_if: request/acknowledge bus between the CPU bus initiator and a memory responder.
// Latency: none, this is wiring only.
// Backpressure: the initiator holds read_q/write_q until the matching *_dn pulse is seen.
interface mem_responder_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) ();
    logic              read_q;
    logic              write_q;
    logic [ADDR_W-1:0] addr_in;
    logic [DATA_W-1:0] data_in;
    logic              read_dn;
    logic              write_dn;
    logic [DATA_W-1:0] data_out;
    logic              bus_busy;

    // Initiator side: drives requests, observes acknowledges.
    modport master (
        output read_q, write_q, addr_in, data_in,
        input  read_dn, write_dn, data_out, bus_busy
    );

    // Responder side: observes requests, drives acknowledges.
    modport slave (
        input  read_q, write_q, addr_in, data_in,
        output read_dn, write_dn, data_out, bus_busy
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: word-addressed on-chip RAM at [BASE, BASE+DEPTH) answering read_q/write_q (MEM_RESP_OOR_ACK_EN also acks out-of-window requests).
// Latency: *_dn (and read data) high in the cycle after edge E(1+LATENCY), E0 being the edge that samples the request.
// Backpressure: requests are held by the initiator; RELEASE waits for the served line to drop so a held request is served once.
module mem_responder #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned BASE    = 0,
    parameter int unsigned LATENCY = 2
) (
    input  logic           clk,
    input  logic           rst,
    mem_responder_if.slave bus
);
    localparam int unsigned       IDX_W      = $clog2(DEPTH);
    // Window bounds carry one extra bit so BASE+DEPTH never wraps.
    localparam logic [ADDR_W:0]   P_LO       = (ADDR_W+1)'(BASE);
    localparam logic [ADDR_W:0]   P_HI       = (ADDR_W+1)'(BASE) + (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] P_BASE     = ADDR_W'(BASE);
    localparam logic [3:0]        P_CNT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_ACK     = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t             r_state;
    logic [3:0]         r_cnt;
    logic               r_is_wr;
    logic [IDX_W-1:0]   r_idx;
    logic [DATA_W-1:0]  r_wdat;
    logic               r_read_dn;
    logic               r_write_dn;
    logic [DATA_W-1:0]  r_data_out;
    logic               r_bus_busy;
    logic [DATA_W-1:0]  r_mem [DEPTH];

    state_t             w_state_nxt;
    logic [3:0]         w_cnt_nxt;
    logic               w_is_wr_nxt;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [DATA_W-1:0]  w_wdat_nxt;
    logic               w_read_dn_nxt;
    logic               w_write_dn_nxt;
    logic [DATA_W-1:0]  w_data_out_nxt;
    logic               w_busy_nxt;
    logic               w_mem_we;
    logic [ADDR_W:0]    w_addr_ext;
    logic               w_in_range;
    logic               w_can_accept;
    logic               w_served_q;
    logic               w_oor;

    assign w_addr_ext = {1'b0, bus.addr_in};
    assign w_in_range = (w_addr_ext >= P_LO) && (w_addr_ext < P_HI);

`ifdef MEM_RESP_OOR_ACK_EN
    logic r_oor;
    logic w_oor_nxt;

    // Out-of-window requests get the full handshake; the flag turns them into no-ops.
    assign w_can_accept = 1'b1;
    assign w_oor        = r_oor;
`else
    // Out-of-window requests are left on the bus for another responder.
    assign w_can_accept = w_in_range;
    assign w_oor        = 1'b0;
`endif

    // Served request line: RELEASE waits for exactly this one to drop.
    assign w_served_q = r_is_wr ? bus.write_q : bus.read_q;

    // Next-state and next-output decode; all outputs are registered below.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_is_wr_nxt    = r_is_wr;
        w_idx_nxt      = r_idx;
        w_wdat_nxt     = r_wdat;
        w_read_dn_nxt  = 1'b0;
        w_write_dn_nxt = 1'b0;
        w_data_out_nxt = '0;
        w_busy_nxt     = r_bus_busy;
        w_mem_we       = 1'b0;
`ifdef MEM_RESP_OOR_ACK_EN
        w_oor_nxt      = r_oor;
`endif
        case (r_state)
            S_IDLE: begin
                // Write wins over a simultaneous read; the read stays pending on the bus.
                if ((bus.write_q || bus.read_q) && w_can_accept) begin
                    w_is_wr_nxt = bus.write_q;
                    w_idx_nxt   = IDX_W'(bus.addr_in - P_BASE);
                    w_wdat_nxt  = bus.data_in;
                    w_cnt_nxt   = P_CNT_LOAD;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = (LATENCY > 0) ? S_WAIT : S_ACK;
`ifdef MEM_RESP_OOR_ACK_EN
                    w_oor_nxt   = !w_in_range;
`endif
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_ACK;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_ACK: begin
                if (r_is_wr) begin
                    w_write_dn_nxt = 1'b1;
                    w_mem_we       = !w_oor;
                end else begin
                    w_read_dn_nxt  = 1'b1;
                    w_data_out_nxt = w_oor ? '0 : r_mem[r_idx];
                end
                w_state_nxt = S_RELEASE;
            end
            S_RELEASE: begin
                if (!w_served_q) begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction not yet acknowledged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_is_wr    <= 1'b0;
            r_idx      <= '0;
            r_wdat     <= '0;
            r_read_dn  <= 1'b0;
            r_write_dn <= 1'b0;
            r_data_out <= '0;
            r_bus_busy <= 1'b0;
`ifdef MEM_RESP_OOR_ACK_EN
            r_oor      <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_is_wr    <= w_is_wr_nxt;
            r_idx      <= w_idx_nxt;
            r_wdat     <= w_wdat_nxt;
            r_read_dn  <= w_read_dn_nxt;
            r_write_dn <= w_write_dn_nxt;
            r_data_out <= w_data_out_nxt;
            r_bus_busy <= w_busy_nxt;
`ifdef MEM_RESP_OOR_ACK_EN
            r_oor      <= w_oor_nxt;
`endif
        end
    end

    // RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_idx] <= r_wdat;
        end
    end

    assign bus.read_dn  = r_read_dn;
    assign bus.write_dn = r_write_dn;
    assign bus.data_out = r_data_out;
    assign bus.bus_busy = r_bus_busy;
endmodule
